// File: rtl/circle_point_sequencer.sv
// Midpoint-circle point generator for the VGA emulator's single-pixel plot inputs.
// Emits one visible circle point per frame; clipped points are skipped without spending a frame.
module circle_point_sequencer #(
   parameter int H_PIX = 640,
   parameter int V_PIX = 480
) (
   input  logic        clk50,
   input  logic        reset_n,
   input  logic        start,
   input  logic        abort,
   input  logic [9:0]  cx,
   input  logic [8:0]  cy,
   input  logic [8:0]  radius,
   input  logic        frame_tick,
   output logic [10:0] x_coor,
   output logic [9:0]  y_coor,
   output logic        busy,
   output logic        done
);

   localparam logic signed [11:0] LP_H = 12'(H_PIX);
   localparam logic signed [11:0] LP_V = 12'(V_PIX);

   typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_WAIT, ST_FINISH} state_t;

   state_t             r_state;
   logic [9:0]         r_cx;
   logic [8:0]         r_cy;
   logic [9:0]         r_xi;
   logic [9:0]         r_yi;
   logic signed [11:0] r_d;
   logic [2:0]         r_oct;
   logic [9:0]         r_sx;
   logic [8:0]         r_sy;
   logic               r_last;
   logic               r_pend;
   logic [10:0]        r_x;
   logic [9:0]         r_y;
   logic               r_busy;
   logic               r_done;

   logic [9:0]         w_a;
   logic [9:0]         w_b;
   logic signed [11:0] w_px;
   logic signed [11:0] w_py;
   logic               w_vis;
   logic               w_step_y;
   logic [9:0]         w_xi_nx;
   logic [9:0]         w_yi_nx;
   logic signed [11:0] w_diff;
   logic signed [11:0] w_d_nx;
   logic               w_more;
   logic               w_last;

   // Octants 4..7 swap the roles of xi and yi; bit 0 negates x, bit 1 negates y.
   always_comb begin
      w_a      = r_oct[2] ? r_yi : r_xi;
      w_b      = r_oct[2] ? r_xi : r_yi;
      w_px     = r_oct[0] ? ($signed({2'b00, r_cx}) - $signed({2'b00, w_a}))
                          : ($signed({2'b00, r_cx}) + $signed({2'b00, w_a}));
      w_py     = r_oct[1] ? ($signed({3'b000, r_cy}) - $signed({2'b00, w_b}))
                          : ($signed({3'b000, r_cy}) + $signed({2'b00, w_b}));
      w_vis    = (w_px >= 12'sd0) && (w_px < LP_H) && (w_py >= 12'sd0) && (w_py < LP_V);
      w_step_y = ~r_d[11];
      w_xi_nx  = r_xi + 10'd1;
      w_yi_nx  = w_step_y ? (r_yi - 10'd1) : r_yi;
      w_diff   = $signed({2'b00, w_xi_nx}) - $signed({2'b00, w_yi_nx});
      w_d_nx   = w_step_y ? (r_d + (w_diff <<< 1) + 12'sd1)
                          : (r_d + $signed({1'b0, w_xi_nx, 1'b0}) + 12'sd1);
      // yi may step below zero, so compare xi+1 <= yi instead of xi <= yi-1.
      w_more   = w_step_y ? (({1'b0, w_xi_nx} + 11'd1) <= {1'b0, r_yi})
                          : ({1'b0, w_xi_nx} <= {1'b0, r_yi});
      w_last   = (r_oct == 3'd7) && !w_more;
   end

   // Sequencer: algorithm stepping, frame pacing, tick bookkeeping and registered outputs.
   always_ff @(posedge clk50 or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
         r_cx    <= 10'd0;
         r_cy    <= 9'd0;
         r_xi    <= 10'd0;
         r_yi    <= 10'd0;
         r_d     <= 12'sd0;
         r_oct   <= 3'd0;
         r_sx    <= 10'd0;
         r_sy    <= 9'd0;
         r_last  <= 1'b0;
         r_pend  <= 1'b0;
         r_x     <= 11'h7FF;
         r_y     <= 10'h3FF;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else if (abort && (r_state != ST_IDLE)) begin
         r_state <= ST_IDLE;
         r_pend  <= 1'b0;
         r_x     <= 11'h7FF;
         r_y     <= 10'h3FF;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start && !abort) begin
                  r_cx    <= cx;
                  r_cy    <= cy;
                  r_xi    <= 10'd0;
                  r_yi    <= {1'b0, radius};
                  r_d     <= 12'sd1 - $signed({3'b000, radius});
                  r_oct   <= 3'd0;
                  r_pend  <= 1'b0;
                  r_busy  <= 1'b1;
                  r_state <= ST_CALC;
               end
            end
            ST_CALC: begin
               if (frame_tick) begin
                  r_pend <= 1'b1;
               end
               if (r_oct == 3'd7) begin
                  r_oct <= 3'd0;
                  r_xi  <= w_xi_nx;
                  r_yi  <= w_yi_nx;
                  r_d   <= w_d_nx;
               end else begin
                  r_oct <= r_oct + 3'd1;
               end
               if (w_vis) begin
                  r_sx    <= w_px[9:0];
                  r_sy    <= w_py[8:0];
                  r_last  <= w_last;
                  r_state <= ST_WAIT;
               end else if (w_last) begin
                  r_state <= ST_FINISH;
               end
            end
            ST_WAIT: begin
               if (frame_tick || r_pend) begin
                  r_x     <= {r_sx, 1'b0};
                  r_y     <= {1'b0, r_sy};
                  r_pend  <= 1'b0;
                  r_state <= r_last ? ST_FINISH : ST_CALC;
               end
            end
            ST_FINISH: begin
               if (frame_tick || r_pend) begin
                  r_x     <= 11'h7FF;
                  r_y     <= 10'h3FF;
                  r_pend  <= 1'b0;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign x_coor = r_x;
   assign y_coor = r_y;
   assign busy   = r_busy;
   assign done   = r_done;

endmodule

// File: tb/tb_circle_point_sequencer.sv
// Self-checking bench for circle_point_sequencer: directed corner cases plus random circles
// compared against a plain-integer midpoint-circle model.
module tb_circle_point_sequencer;

   localparam int GAP = 80;

   logic        clk50 = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [9:0]  cx = 10'd0;
   logic [8:0]  cy = 9'd0;
   logic [8:0]  radius = 9'd0;
   logic        frame_tick = 1'b0;
   logic [10:0] x_coor;
   logic [9:0]  y_coor;
   logic        busy;
   logic        done;

   int n_checks = 0;
   int n_fails  = 0;
   int done_cnt = 0;
   int exp_x[$];
   int exp_y[$];

   circle_point_sequencer #(.H_PIX(640), .V_PIX(480)) dut (
      .clk50(clk50), .reset_n(reset_n), .start(start), .abort(abort),
      .cx(cx), .cy(cy), .radius(radius), .frame_tick(frame_tick),
      .x_coor(x_coor), .y_coor(y_coor), .busy(busy), .done(done)
   );

   always #10 clk50 = ~clk50;

   always @(posedge clk50) begin
      if (done) done_cnt <= done_cnt + 1;
   end

   task automatic chk(input string tag, input int obs, input int exp_v);
      n_checks++;
      if (obs != exp_v) begin
         n_fails++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp_v, exp_v);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk50);
   endtask

   task automatic tick();
      frame_tick = 1'b1;
      @(negedge clk50);
      frame_tick = 1'b0;
   endtask

   // Visible points of the circle in emission order, straight from the algorithm's rules.
   task automatic build_model(input int cxv, input int cyv, input int rv);
      int xi, yi, d;
      int px[8];
      int py[8];
      exp_x.delete();
      exp_y.delete();
      xi = 0; yi = rv; d = 1 - rv;
      while (xi <= yi) begin
         px = '{cxv + xi, cxv - xi, cxv + xi, cxv - xi, cxv + yi, cxv - yi, cxv + yi, cxv - yi};
         py = '{cyv + yi, cyv + yi, cyv - yi, cyv - yi, cyv + xi, cyv + xi, cyv - xi, cyv - xi};
         for (int k = 0; k < 8; k++) begin
            if (px[k] >= 0 && px[k] < 640 && py[k] >= 0 && py[k] < 480) begin
               exp_x.push_back(px[k]);
               exp_y.push_back(py[k]);
            end
         end
         xi = xi + 1;
         if (d < 0) d = d + 2 * xi + 1;
         else begin
            yi = yi - 1;
            d = d + 2 * (xi - yi) + 1;
         end
      end
   endtask

   task automatic pulse_start(input int cxv, input int cyv, input int rv);
      cx = 10'(cxv); cy = 9'(cyv); radius = 9'(rv); start = 1'b1;
      @(negedge clk50);
      start = 1'b0;
      cx = 10'($urandom_range(0, 1023)); cy = 9'($urandom_range(0, 511));
      radius = 9'($urandom_range(0, 511));
   endtask

   task automatic run_circle(input int cxv, input int cyv, input int rv);
      int d0;
      build_model(cxv, cyv, rv);
      pulse_start(cxv, cyv, rv);
      chk("busy_rise", busy, 1);
      chk("pre_x", x_coor, 11'h7FF);
      chk("pre_y", y_coor, 10'h3FF);
      d0 = done_cnt;
      for (int i = 0; i < exp_x.size(); i++) begin
         tick();
         if (i == 0) pulse_start(cxv + 7, cyv + 3, rv + 1);
         wait_cyc(GAP);
         chk("pt_x", x_coor, 2 * exp_x[i]);
         chk("pt_y", y_coor, exp_y[i]);
         chk("pt_busy", busy, 1);
      end
      chk("no_early_done", done_cnt, d0);
      tick();
      wait_cyc(GAP);
      chk("end_x", x_coor, 11'h7FF);
      chk("end_y", y_coor, 10'h3FF);
      chk("end_busy", busy, 0);
      chk("done_once", done_cnt, d0 + 1);
   endtask

   initial begin
      int d0;
      wait_cyc(3);
      chk("rst_x", x_coor, 11'h7FF);
      chk("rst_y", y_coor, 10'h3FF);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      reset_n = 1'b1;
      wait_cyc(2);

      // start with no frame tick: busy, outputs remain sentinel
      pulse_start(100, 50, 0);
      wait_cyc(20);
      chk("idle_busy", busy, 1);
      chk("idle_x", x_coor, 11'h7FF);
      abort = 1'b1; @(negedge clk50); abort = 1'b0;
      chk("abort0_busy", busy, 0);

      run_circle(100, 50, 0);
      run_circle(10, 10, 1);
      run_circle(0, 0, 2);

      // start and abort together in IDLE: abort wins
      cx = 10'd50; cy = 9'd50; radius = 9'd3; start = 1'b1; abort = 1'b1;
      @(negedge clk50);
      start = 1'b0; abort = 1'b0;
      wait_cyc(3);
      chk("start_abort_busy", busy, 0);

      // abort on the 3rd frame of an r=5 circle
      build_model(100, 100, 5);
      d0 = done_cnt;
      pulse_start(100, 100, 5);
      for (int i = 0; i < 3; i++) begin
         tick();
         wait_cyc(GAP);
         chk("ab_pt_x", x_coor, 2 * exp_x[i]);
         chk("ab_pt_y", y_coor, exp_y[i]);
      end
      abort = 1'b1; @(negedge clk50); abort = 1'b0;
      chk("ab_x", x_coor, 11'h7FF);
      chk("ab_y", y_coor, 10'h3FF);
      chk("ab_busy", busy, 0);
      tick();
      wait_cyc(GAP);
      chk("ab_no_done", done_cnt, d0);
      run_circle(100, 100, 5);

      // tick arrives while still in CALC; pending flag publishes on WAIT entry
      build_model(320, 240, 100);
      cx = 10'd320; cy = 9'd240; radius = 9'd100; start = 1'b1;
      @(negedge clk50);
      start = 1'b0; frame_tick = 1'b1;
      @(negedge clk50);
      frame_tick = 1'b0;
      @(negedge clk50);
      chk("pend_x", x_coor, 2 * exp_x[0]);
      chk("pend_y", y_coor, exp_y[0]);
      pulse_start(5, 5, 7);
      for (int i = 1; i < 4; i++) begin
         tick();
         wait_cyc(10);
         chk("pend_seq_x", x_coor, 2 * exp_x[i]);
         chk("pend_seq_y", y_coor, exp_y[i]);
      end
      abort = 1'b1; @(negedge clk50); abort = 1'b0;
      chk("pend_abort_busy", busy, 0);

      // reset in the middle of a circle
      pulse_start(200, 200, 4);
      tick();
      wait_cyc(10);
      reset_n = 1'b0;
      #1;
      chk("mid_rst_x", x_coor, 11'h7FF);
      chk("mid_rst_busy", busy, 0);
      wait_cyc(2);
      reset_n = 1'b1;
      wait_cyc(2);

      for (int n = 0; n < 6; n++) begin
         run_circle($urandom_range(0, 700), $urandom_range(0, 520), $urandom_range(0, 10));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
